// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, header field layout and the
// control FSM state encoding.
package router_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W     = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_MSB = ADDR_W - 1;
    localparam int HDR_LEN_LSB  = ADDR_W;
    localparam int HDR_LEN_MSB  = DATA_W_DEF - 1;

    typedef enum logic [2:0] {
        ST_DECODE_ADDRESS     = 3'd0,
        ST_LOAD_FIRST_DATA    = 3'd1,
        ST_LOAD_DATA          = 3'd2,
        ST_LOAD_PARITY        = 3'd3,
        ST_FIFO_FULL_STATE    = 3'd4,
        ST_LOAD_AFTER_FULL    = 3'd5,
        ST_WAIT_TILL_EMPTY    = 3'd6,
        ST_CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

endpackage

// File: rtl/router_reg_if.sv
// Byte stream and FSM strobe bundle between the router control FSM (master)
// and the router datapath register stage (slave).
interface router_reg_if #(parameter int DATA_W = 8);

    logic              pkt_valid;
    logic [DATA_W-1:0] din;
    logic              fifo_full;
    logic              detect_add;
    logic              lfd_state;
    logic              ld_state;
    logic              laf_state;
    logic              full_state;
    logic              rst_int_reg;
    logic [DATA_W-1:0] dout;
    logic              parity_done;
    logic              low_pkt_vld;
    logic              err;

    modport master (
        output pkt_valid, din, fifo_full,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        input  dout, parity_done, low_pkt_vld, err
    );

    modport slave (
        input  pkt_valid, din, fifo_full,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
        output dout, parity_done, low_pkt_vld, err
    );

endinterface

// File: rtl/router_parity_acc.sv
// Running XOR parity over header and payload, captured packet parity byte and
// the sticky mismatch flag. Only built when ROUTER_PARITY_CHECK_EN is defined.
module router_parity_acc
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              ld_hdr,
    input  logic [DATA_W-1:0] hdr,
    input  logic              acc,
    input  logic              cap,
    input  logic [DATA_W-1:0] din,
    input  logic              chk,
    input  logic              err_clr,
    output logic              err
);

    logic [DATA_W-1:0] int_par;
    logic [DATA_W-1:0] pkt_par;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            int_par <= '0;
            pkt_par <= '0;
            err     <= 1'b0;
        end else begin
            if (clr)
                int_par <= '0;
            else if (ld_hdr)
                int_par <= hdr;
            else if (acc)
                int_par <= int_par ^ din;

            if (cap)
                pkt_par <= din;

            // err stays sticky once parity_done drops, until the next header load
            if (err_clr)
                err <= 1'b0;
            else if (chk)
                err <= (int_par != pkt_par);
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, full-FIFO hold byte, dout
// steering and end-of-packet flags. Parity checking under ROUTER_PARITY_CHECK_EN.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    router_reg_if.slave  bus
);

    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] header_q;
    logic [DATA_W-1:0] hold_q;
    logic              parity_done_q;
    logic              low_pkt_vld_q;
    logic              err_w;
    logic              addr_ok;

    assign addr_ok = (bus.din[HDR_ADDR_MSB:HDR_ADDR_LSB] != ADDR_INVALID);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_q        <= '0;
            header_q      <= '0;
            hold_q        <= '0;
            parity_done_q <= 1'b0;
            low_pkt_vld_q <= 1'b0;
        end else begin
            if (bus.detect_add && bus.pkt_valid && addr_ok)
                header_q <= bus.din;

            if (bus.lfd_state)
                dout_q <= header_q;
            else if (bus.ld_state && !bus.fifo_full)
                dout_q <= bus.din;
            else if (bus.ld_state && bus.fifo_full)
                hold_q <= bus.din;
            else if (bus.laf_state)
                dout_q <= hold_q;

            if (bus.ld_state && !bus.pkt_valid)
                low_pkt_vld_q <= 1'b1;
            else if (bus.rst_int_reg)
                low_pkt_vld_q <= 1'b0;

            // parity byte may land directly or via the hold register after a full stall
            if ((bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                (bus.laf_state && low_pkt_vld_q && !parity_done_q))
                parity_done_q <= 1'b1;
            else if (bus.detect_add)
                parity_done_q <= 1'b0;
        end
    end

`ifdef ROUTER_PARITY_CHECK_EN
    router_parity_acc #(.DATA_W(DATA_W)) u_parity_acc (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (bus.detect_add),
        .ld_hdr  (bus.lfd_state),
        .hdr     (header_q),
        .acc     (bus.ld_state && bus.pkt_valid),
        .cap     (bus.ld_state && !bus.pkt_valid),
        .din     (bus.din),
        .chk     (parity_done_q),
        .err_clr (bus.lfd_state),
        .err     (err_w)
    );
`else
    assign err_w = 1'b0;
`endif

    assign bus.dout        = dout_q;
    assign bus.parity_done = parity_done_q;
    assign bus.low_pkt_vld = low_pkt_vld_q;
    assign bus.err         = err_w;

endmodule
